// File: rtl/adder_pkg.sv
// Shared types and default sizing for the nibble-serial subtractor.
package adder_pkg;

  localparam int DEFAULT_TOTAL_WIDTH = 32;
  localparam int DEFAULT_NIBBLE_SIZE = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/nibble_serial_subtractor_if.sv
// Operand/result handshake bundle for nibble_serial_subtractor.
// master = operand producer / result consumer, slave = the subtractor.
interface nibble_serial_subtractor_if #(
  parameter int TOTAL_WIDTH = adder_pkg::DEFAULT_TOTAL_WIDTH
);
  logic                   in_valid_i;
  logic                   in_ready_o;
  logic [TOTAL_WIDTH-1:0] a_i;
  logic [TOTAL_WIDTH-1:0] b_i;
  logic                   bin_i;
  logic                   out_valid_o;
  logic                   out_ready_i;
  logic [TOTAL_WIDTH-1:0] diff_o;
  logic                   bout_o;
  logic                   ovf_o;

  modport master (
    output in_valid_i, a_i, b_i, bin_i, out_ready_i,
    input  in_ready_o, out_valid_o, diff_o, bout_o, ovf_o
  );

  modport slave (
    input  in_valid_i, a_i, b_i, bin_i, out_ready_i,
    output in_ready_o, out_valid_o, diff_o, bout_o, ovf_o
  );
endinterface

// File: rtl/nibble_sub_stage.sv
// One nibble of subtraction expressed as a + ~b + cin (two's-complement add).
// Purely combinational; the caller owns the carry register.
module nibble_sub_stage #(
  parameter int NIBBLE_SIZE = 4
) (
  input  logic [NIBBLE_SIZE-1:0] a_i,
  input  logic [NIBBLE_SIZE-1:0] b_i,
  input  logic                   cin_i,
  output logic [NIBBLE_SIZE-1:0] sum_o,
  output logic                   cout_o
);
  logic [NIBBLE_SIZE-1:0] b_n;

  assign b_n = ~b_i;
  // Widen by one bit so the top bit of the sum is the nibble carry-out.
  assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_n} + {{NIBBLE_SIZE{1'b0}}, cin_i};
endmodule

// File: rtl/nibble_serial_subtractor.sv
// Nibble-serial subtractor: diff = a - b - bin, one NIBBLE_SIZE slice per cycle.
// Accept in IDLE, walk nibbles LSB-first in RUN, present result in DONE until
// the consumer takes it. Optional signed-overflow flag: SUB_OVERFLOW_FLAG_EN.
// TOTAL_WIDTH must be an integer multiple of NIBBLE_SIZE.
module nibble_serial_subtractor
  import adder_pkg::*;
#(
  parameter int TOTAL_WIDTH = DEFAULT_TOTAL_WIDTH,
  parameter int NIBBLE_SIZE = DEFAULT_NIBBLE_SIZE
) (
  input logic                       clk_i,
  input logic                       rst_i,
  nibble_serial_subtractor_if.slave bus
);
  localparam int NUM_NIBBLES = TOTAL_WIDTH / NIBBLE_SIZE;
  localparam int IDX_W       = (NUM_NIBBLES > 1) ? $clog2(NUM_NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NIBBLES - 1);

  state_e state_q, state_d;

  logic [TOTAL_WIDTH-1:0] a_q, a_d;
  logic [TOTAL_WIDTH-1:0] b_q, b_d;
  logic [TOTAL_WIDTH-1:0] work_q, work_d;   // partial difference built in RUN
  logic [TOTAL_WIDTH-1:0] diff_q, diff_d;   // visible result, updated once per op
  logic                   carry_q, carry_d;
  logic                   bout_q, bout_d;
  logic [IDX_W-1:0]       idx_q, idx_d;

  logic [NIBBLE_SIZE-1:0] nib_a, nib_b, nib_sum;
  logic                   nib_cout;
  logic                   last_nib;
  logic                   in_ready, out_valid;

  assign nib_a    = a_q[idx_q*NIBBLE_SIZE +: NIBBLE_SIZE];
  assign nib_b    = b_q[idx_q*NIBBLE_SIZE +: NIBBLE_SIZE];
  assign last_nib = (state_q == RUN) && (idx_q == LAST_IDX);

  nibble_sub_stage #(
    .NIBBLE_SIZE(NIBBLE_SIZE)
  ) u_stage (
    .a_i   (nib_a),
    .b_i   (nib_b),
    .cin_i (carry_q),
    .sum_o (nib_sum),
    .cout_o(nib_cout)
  );

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.in_valid_i)  state_d = RUN;
      RUN:     if (idx_q == LAST_IDX) state_d = DONE;
      DONE:    if (bus.out_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs decoded from state
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
  end

  assign bus.in_ready_o  = in_ready;
  assign bus.out_valid_o = out_valid;
  assign bus.diff_o      = diff_q;
  assign bus.bout_o      = bout_q;

  // Datapath next values: capture on accept, one nibble per RUN cycle,
  // publish diff/bout only when the last nibble lands so outputs never glitch.
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    work_d  = work_q;
    diff_d  = diff_q;
    carry_d = carry_q;
    bout_d  = bout_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid_i) begin
          a_d     = bus.a_i;
          b_d     = bus.b_i;
          carry_d = ~bus.bin_i;   // a - b - bin == a + ~b + ~bin
          idx_d   = '0;
        end
      end
      RUN: begin
        work_d[idx_q*NIBBLE_SIZE +: NIBBLE_SIZE] = nib_sum;
        carry_d = nib_cout;
        idx_d   = last_nib ? '0 : idx_q + 1'b1;
        if (last_nib) begin
          diff_d = work_d;
          bout_d = ~nib_cout;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      a_q     <= '0;
      b_q     <= '0;
      work_q  <= '0;
      diff_q  <= '0;
      carry_q <= 1'b0;
      bout_q  <= 1'b0;
      idx_q   <= '0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      work_q  <= work_d;
      diff_q  <= diff_d;
      carry_q <= carry_d;
      bout_q  <= bout_d;
      idx_q   <= idx_d;
    end
  end

`ifdef SUB_OVERFLOW_FLAG_EN
  logic ovf_q, ovf_d;

  // Signed overflow: operands differ in sign and result sign differs from a.
  always_comb begin
    ovf_d = ovf_q;
    if (last_nib)
      ovf_d = (a_q[TOTAL_WIDTH-1] ^ b_q[TOTAL_WIDTH-1]) &
              (a_q[TOTAL_WIDTH-1] ^ nib_sum[NIBBLE_SIZE-1]);
  end

  // Overflow register, updated alongside diff
  always_ff @(posedge clk_i) begin
    if (rst_i) ovf_q <= 1'b0;
    else       ovf_q <= ovf_d;
  end

  assign bus.ovf_o = ovf_q;
`else
  assign bus.ovf_o = 1'b0;
`endif

endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// Bench for nibble_serial_subtractor: vector table, hand-written corner
// sequences (backpressure, mid-run reset) and a random stream, all checked
// through a scoreboard queue filled at accept and drained at result handoff.
module tb_nibble_serial_subtractor;
  localparam int W   = 32;
  localparam int LAT = 9;  // accept-edge sample to first out_valid sample

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf_en;  // ovf expected when the overflow flag is built in
  } vec_t;

  typedef struct {
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;
    int           acc_cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  nibble_serial_subtractor_if #(.TOTAL_WIDTH(W)) bus ();

  nibble_serial_subtractor #(
    .TOTAL_WIDTH(W),
    .NIBBLE_SIZE(4)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  int n_cmp = 0, n_err = 0;
  int cyc = 0, n_push = 0, n_pop = 0;
  bit rnd_rdy = 0, acc_flag = 0;
  bit prev_ov = 0, prev_hs = 0;
  logic [W-1:0] prev_diff;
  logic prev_bout, prev_ovf;
  exp_t sb[$];
  exp_t pend;
  vec_t tbl[9];

  function automatic exp_t model(logic [W-1:0] a, logic [W-1:0] b, logic bin);
    exp_t e;
    logic [W:0] r;
    r = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bin};
    e.diff = r[W-1:0];
    e.bout = r[W];
`ifdef SUB_OVERFLOW_FLAG_EN
    e.ovf = (a[W-1] ^ b[W-1]) & (a[W-1] ^ r[W-1]);
`else
    e.ovf = 1'b0;
`endif
    e.acc_cyc = 0;
    return e;
  endfunction

  task automatic chk(string nm, logic [W-1:0] act, logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic fail(string nm);
    n_cmp++;
    n_err++;
    $display("FAIL %s (cycle %0d)", nm, cyc);
  endtask

  // Observe at the falling edge: push on accept, check hold/latency, pop on handoff.
  task automatic mon();
    exp_t e;
    if (rst) begin
      sb.delete();
      prev_ov = 0;
      prev_hs = 0;
      return;
    end
    if (bus.in_valid_i && bus.in_ready_o) begin
      e = pend;
      e.acc_cyc = cyc;
      sb.push_back(e);
      n_push++;
      acc_flag = 1;
    end
    if (bus.out_valid_o) begin
      chk("in_ready_low_in_done", W'(bus.in_ready_o), W'(0));
      if (!prev_ov) begin
        if (sb.size() == 0) fail("unexpected_result");
        else chk("latency", W'(cyc - sb[0].acc_cyc), W'(LAT));
      end else if (!prev_hs) begin
        chk("hold_diff", bus.diff_o, prev_diff);
        chk("hold_bout", W'(bus.bout_o), W'(prev_bout));
        chk("hold_ovf",  W'(bus.ovf_o),  W'(prev_ovf));
      end
      if (bus.out_ready_i && sb.size() > 0) begin
        e = sb.pop_front();
        n_pop++;
        chk("diff", bus.diff_o, e.diff);
        chk("bout", W'(bus.bout_o), W'(e.bout));
        chk("ovf",  W'(bus.ovf_o),  W'(e.ovf));
      end
    end
    prev_ov   = bus.out_valid_o;
    prev_hs   = bus.out_valid_o && bus.out_ready_i;
    prev_diff = bus.diff_o;
    prev_bout = bus.bout_o;
    prev_ovf  = bus.ovf_o;
  endtask

  // One clock: monitor at negedge, then step past the rising edge.
  task automatic cycle();
    @(negedge clk);
    mon();
    @(posedge clk);
    cyc++;
    #1;
    if (rnd_rdy) bus.out_ready_i = 1'($urandom_range(0, 1));
  endtask

  task automatic send(logic [W-1:0] a, logic [W-1:0] b, logic bin, exp_t e);
    bus.a_i = a;
    bus.b_i = b;
    bus.bin_i = bin;
    bus.in_valid_i = 1'b1;
    pend = e;
    acc_flag = 0;
    for (int i = 0; i < 100 && !acc_flag; i++) cycle();
    bus.in_valid_i = 1'b0;
    if (!acc_flag) fail("accept_timeout");
  endtask

  task automatic wait_idle();
    int i;
    for (i = 0; i < 200; i++) begin
      if (sb.size() == 0 && !bus.out_valid_o) break;
      cycle();
    end
    if (i == 200) fail("drain_timeout");
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    repeat (3) cycle();
    rst = 1'b0;
  endtask

  initial begin
    exp_t e;
    logic [W-1:0] ra, rb;
    logic rbin;

    bus.in_valid_i  = 1'b0;
    bus.a_i         = '0;
    bus.b_i         = '0;
    bus.bin_i       = 1'b0;
    bus.out_ready_i = 1'b1;

    tbl[0] = '{32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0002, 1'b0, 1'b0};
    tbl[1] = '{32'h0000_0000, 32'h0000_0001, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0};
    tbl[2] = '{32'h1234_5678, 32'h1234_5678, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0};
    tbl[3] = '{32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1};
    tbl[4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000, 1'b0, 1'b0};
    tbl[5] = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h8000_0000, 1'b1, 1'b1};
    tbl[6] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0};
    tbl[7] = '{32'h0000_0010, 32'h0000_000F, 1'b1, 32'h0000_0000, 1'b0, 1'b0};
    tbl[8] = '{32'hA5A5_0000, 32'h0000_0001, 1'b0, 32'hA5A4_FFFF, 1'b0, 1'b0};

    // Reset state
    reset_dut();
    chk("rst_out_valid", W'(bus.out_valid_o), W'(0));
    chk("rst_in_ready",  W'(bus.in_ready_o),  W'(1));
    chk("rst_diff",      bus.diff_o,          W'(0));
    chk("rst_bout",      W'(bus.bout_o),      W'(0));
    chk("rst_ovf",       W'(bus.ovf_o),       W'(0));

    // Vector table
    foreach (tbl[i]) begin
      e.diff = tbl[i].diff;
      e.bout = tbl[i].bout;
`ifdef SUB_OVERFLOW_FLAG_EN
      e.ovf = tbl[i].ovf_en;
`else
      e.ovf = 1'b0;
`endif
      e.acc_cyc = 0;
      send(tbl[i].a, tbl[i].b, tbl[i].bin, e);
    end
    wait_idle();

    // Backpressure: hold result 5 cycles while new operands toggle
    bus.out_ready_i = 1'b0;
    send(32'h0000_1234, 32'h0000_0235, 1'b0, model(32'h0000_1234, 32'h0000_0235, 1'b0));
    begin
      int i;
      for (i = 0; i < 30 && !bus.out_valid_o; i++) cycle();
      if (!bus.out_valid_o) fail("bp_out_valid_timeout");
    end
    for (int i = 0; i < 5; i++) begin
      bus.in_valid_i = 1'(i % 2 == 0);
      bus.a_i = $urandom;
      bus.b_i = $urandom;
      bus.bin_i = 1'($urandom_range(0, 1));
      cycle();
    end
    bus.in_valid_i = 1'b0;
    bus.out_ready_i = 1'b1;
    wait_idle();

    // Reset while nibble 3 is being processed, then a fresh op
    send(32'hFFFF_0000, 32'h0000_0001, 1'b0, model(32'hFFFF_0000, 32'h0000_0001, 1'b0));
    repeat (3) cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("midrst_out_valid", W'(bus.out_valid_o), W'(0));
    chk("midrst_in_ready",  W'(bus.in_ready_o),  W'(1));
    chk("midrst_diff",      bus.diff_o,          W'(0));
    e.diff = 32'd6;
    e.bout = 1'b0;
    e.ovf  = 1'b0;
    e.acc_cyc = 0;
    send(32'd10, 32'd4, 1'b0, e);
    wait_idle();

    // Random stream with random in_valid gaps and out_ready
    n_push = 0;
    n_pop  = 0;
    rnd_rdy = 1;
    for (int k = 0; k < 1000; k++) begin
      repeat ($urandom_range(0, 2)) cycle();
      ra = $urandom;
      rb = (k % 8 == 0) ? ra : $urandom;
      rbin = 1'($urandom_range(0, 1));
      send(ra, rb, rbin, model(ra, rb, rbin));
    end
    rnd_rdy = 0;
    bus.out_ready_i = 1'b1;
    wait_idle();
    chk("stream_count", W'(n_pop), W'(n_push));
    chk("stream_total", W'(n_push), W'(1000));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/nibble_serial_subtractor.md
NIBBLE_SERIAL_SUBTRACTOR -- requirements
Module: nibble_serial_subtractor

Interface
REQ-001 Parameter TOTAL_WIDTH, default 32, operand and result width.
REQ-002 Parameter NIBBLE_SIZE, default 4, number of bits processed per cycle; TOTAL_WIDTH SHALL be an integer multiple of NIBBLE_SIZE.
REQ-003 clk_i  input  1  the single clock; all state SHALL update on its rising edge.
REQ-004 rst_i  input  1  reset; synchronous, active-high.
REQ-005 in_valid_i  input  1  operands present.
REQ-006 in_ready_o  output  1  block can accept operands.
REQ-007 a_i  input  TOTAL_WIDTH  minuend.
REQ-008 b_i  input  TOTAL_WIDTH  subtrahend.
REQ-009 bin_i  input  1  borrow-in.
REQ-010 out_valid_o  output  1  result valid.
REQ-011 out_ready_i  input  1  consumer accepts the result.
REQ-012 diff_o  output  TOTAL_WIDTH  a_i - b_i - bin_i, modulo 2^TOTAL_WIDTH.
REQ-013 bout_o  output  1  borrow-out, 1 when the unsigned a_i < b_i + bin_i.
REQ-014 ovf_o  output  1  signed overflow flag (see Configuration).

Function
REQ-015 The FSM SHALL have the states IDLE, RUN and DONE; NUM_NIBBLES = TOTAL_WIDTH/NIBBLE_SIZE.
REQ-016 IDLE: in_ready_o=1; when in_valid_i=1, a_i, b_i and bin_i SHALL be captured, the carry register set to ~bin_i, the nibble index set to 0, and the FSM SHALL enter RUN.
REQ-017 RUN: each cycle SHALL compute nibble k as a[k] + ~b[k] + carry, write it to diff bits [k*NIBBLE_SIZE +: NIBBLE_SIZE], register the nibble carry-out and increment k.
REQ-018 RUN SHALL enter DONE after processing nibble NUM_NIBBLES-1; operands accepted in cycle N SHALL make out_valid_o=1 from cycle N+NUM_NIBBLES+1 onward (cycle N+9 at the defaults).
REQ-019 DONE: out_valid_o=1; bout_o SHALL equal ~(final carry); diff_o, bout_o and ovf_o SHALL remain stable until out_ready_i=1.
REQ-020 DONE with out_ready_i=1 SHALL return to IDLE on the next cycle; in_ready_o SHALL be 0 in RUN and DONE, so there is no accept in the same cycle as a handoff.
REQ-021 in_valid_i during RUN or DONE SHALL be ignored and SHALL NOT corrupt the captured operands.
REQ-022 In IDLE and RUN, out_valid_o SHALL be 0 and diff_o SHALL hold its last value.

Reset
REQ-023 When rst_i=1 at a clock edge, the FSM SHALL go to IDLE from any state, including mid-RUN; the in-flight operation SHALL be discarded.
REQ-024 Reset values SHALL be: out_valid_o=0, in_ready_o=1 (from the first cycle after reset), diff_o=0, bout_o=0, ovf_o=0, nibble index 0, carry 0.

Configuration
REQ-025 Macro SUB_OVERFLOW_FLAG_EN, when defined, SHALL make ovf_o = (a[MSB]^b[MSB]) & (a[MSB]^diff[MSB]), registered with diff_o and held through DONE.
REQ-026 When SUB_OVERFLOW_FLAG_EN is undefined, ovf_o SHALL be tied to 0, the port SHALL remain present, and no overflow logic SHALL be synthesised.

Structure
REQ-027 The shared package adder_pkg SHALL hold the FSM state typedef (IDLE/RUN/DONE) and the default TOTAL_WIDTH/NIBBLE_SIZE constants.
REQ-028 One sub-module, nibble_sub_stage (parameter NIBBLE_SIZE), SHALL implement the combinational a + ~b + cin and produce sum and carry-out; all sequencing SHALL live in the top module.

Verification
REQ-029 a=32'h0000_0005, b=32'h0000_0003, bin=0 -> diff=32'h0000_0002, bout=0, out_valid_o rises exactly 9 cycles after accept.
REQ-030 a=0, b=1, bin=0 -> diff=32'hFFFF_FFFF, bout=1, ovf=0; a=32'h1234_5678, b=32'h1234_5678, bin=1 -> diff=32'hFFFF_FFFF, bout=1.
REQ-031 With SUB_OVERFLOW_FLAG_EN defined: a=32'h8000_0000, b=1, bin=0 -> diff=32'h7FFF_FFFF, ovf=1, bout=0; without the macro -> ovf=0.
REQ-032 Backpressure: out_ready_i=0 for 5 cycles in DONE, with in_valid_i=1 and new operands toggling -> outputs stable and in_ready_o=0 throughout; the first result is delivered unchanged.
REQ-033 rst_i pulsed while processing nibble 3 -> next cycle out_valid_o=0 and in_ready_o=1; a following a=10, b=4 -> diff=6.
REQ-034 Random back-to-back stream (1000 ops, random in_valid/out_ready) -> every result matches the reference model a-b-bin, and no operation is lost or duplicated.
